// File: rtl/ac_table_pkg.sv
// ac_table_pkg: shared sizes, record/error encodings and loader FSM states for the Aho-Corasick tables
package ac_table_pkg;
  localparam int DEPTH = 32;
  localparam int STATE_W = 8;
  localparam int CHARA_W = 8;
  localparam logic [STATE_W-1:0] INVALID_STATE = 8'hFF;
  localparam logic REC_GOTO = 1'b0;
  localparam logic REC_FAIL = 1'b1;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_FIDX = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_e;
endpackage

// File: rtl/ac_table_ram.sv
// ac_table_ram: simple dual-port RAM, synchronous write, asynchronous read
module ac_table_ram #(
  parameter int W = 8,
  parameter int D = 32,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/table_writer.sv
// table_writer: clears and loads the goto/failure tables from a host record stream
module table_writer
  import ac_table_pkg::*;
#(
  parameter int DEPTH = ac_table_pkg::DEPTH,
  parameter int STATE_W = ac_table_pkg::STATE_W,
  parameter int CHARA_W = ac_table_pkg::CHARA_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic                         IN_TYPE,
  input  logic [STATE_W-1:0]           IN_STATE,
  input  logic [CHARA_W-1:0]           IN_CHARA,
  input  logic [STATE_W-1:0]           IN_NEXT,
  input  logic                         IN_LAST,
  output logic [$clog2(DEPTH+1)-1:0]   GOTO_COUNT,
  output logic                         TABLE_VALID,
  output logic                         ERR,
  output logic [1:0]                   ERR_CODE,
  input  logic [$clog2(DEPTH)-1:0]     RD_ADDR,
  output logic [STATE_W-1:0]           RD_CUR,
  output logic [CHARA_W-1:0]           RD_CHARA,
  output logic [STATE_W-1:0]           RD_NEXT,
  input  logic [STATE_W-1:0]           FAIL_ADDR,
  output logic [STATE_W-1:0]           FAIL_STATE
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = 2*STATE_W + CHARA_W;
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [1:0] code_q, code_d;
  logic clearing, xfer, full, fidx_ok, err_new, goto_we, fail_we;
  logic [1:0] err_val;
  logic [AW-1:0] goto_waddr, fail_waddr, fail_raddr;
  logic [GW-1:0] goto_wdata, goto_rdata;
  logic [STATE_W-1:0] fail_wdata, fail_rdata;
  assign IN_READY = state_q == S_LOAD;
  assign TABLE_VALID = state_q == S_DONE;
  assign GOTO_COUNT = cnt_q;
  assign ERR = err_q;
  assign ERR_CODE = code_q;
  assign {RD_CUR, RD_CHARA, RD_NEXT} = goto_rdata;
  assign fail_raddr = AW'(FAIL_ADDR - STATE_W'(1));
  assign FAIL_STATE = (FAIL_ADDR != '0 && FAIL_ADDR <= STATE_W'(DEPTH)) ? fail_rdata : '0;
  // START overrides any coincident transfer, so it gates every write path
  always_comb begin
    clearing = state_q == S_CLEAR && !START;
    xfer = IN_VALID && IN_READY && !START;
    full = cnt_q == CW'(DEPTH);
    fidx_ok = IN_STATE != '0 && IN_STATE <= STATE_W'(DEPTH);
    err_new = xfer && (IN_TYPE == REC_GOTO ? full : !fidx_ok);
    err_val = IN_TYPE == REC_GOTO ? ERR_OVF : ERR_FIDX;
    goto_we = clearing || (xfer && IN_TYPE == REC_GOTO && !full);
    fail_we = clearing || (xfer && IN_TYPE == REC_FAIL && fidx_ok);
    goto_waddr = clearing ? addr_q : cnt_q[AW-1:0];
    goto_wdata = clearing ? {STATE_W'(INVALID_STATE), {(CHARA_W+STATE_W){1'b0}}}
                          : {IN_STATE, IN_CHARA, IN_NEXT};
    fail_waddr = clearing ? addr_q : AW'(IN_STATE - STATE_W'(1));
    fail_wdata = clearing ? '0 : IN_NEXT;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    err_d = err_q || err_new;
    code_d = (err_new && !err_q) ? err_val : code_q;
    if (START) begin
      state_d = S_CLEAR;
      addr_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
      code_d = ERR_NONE;
    end else if (state_q == S_CLEAR) begin
      addr_d = addr_q + AW'(1);
      state_d = addr_q == AW'(DEPTH-1) ? S_LOAD : S_CLEAR;
    end else if (xfer) begin
      cnt_d = (IN_TYPE == REC_GOTO && !full) ? cnt_q + CW'(1) : cnt_q;
      state_d = IN_LAST ? S_DONE : S_LOAD;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end
  ac_table_ram #(.W(GW), .D(DEPTH)) u_goto (
    .clk(CLK), .we(goto_we), .waddr(goto_waddr), .wdata(goto_wdata),
    .raddr(RD_ADDR), .rdata(goto_rdata)
  );
  ac_table_ram #(.W(STATE_W), .D(DEPTH)) u_fail (
    .clk(CLK), .we(fail_we), .waddr(fail_waddr), .wdata(fail_wdata),
    .raddr(fail_raddr), .rdata(fail_rdata)
  );
endmodule

// File: tb/tb_table_writer.sv
// tb_table_writer: directed + randomized checks of table_writer against an array-based reference model
module tb_table_writer;
  logic CLK = 0, RST = 1, START = 0, IN_VALID = 0, IN_TYPE = 0, IN_LAST = 0;
  logic [7:0] IN_STATE = 0, IN_CHARA = 0, IN_NEXT = 0, FAIL_ADDR = 0;
  logic IN_READY, TABLE_VALID, ERR;
  logic [5:0] GOTO_COUNT;
  logic [1:0] ERR_CODE;
  logic [4:0] RD_ADDR = 0;
  logic [7:0] RD_CUR, RD_CHARA, RD_NEXT, FAIL_STATE;
  int checks = 0, errors = 0;
  logic [23:0] m_goto [32];
  logic [7:0] m_fail [32];
  int m_cnt = 0;
  bit m_ready = 0, m_valid = 0, m_err = 0, m_known = 0;
  logic [1:0] m_code = 0;

  table_writer dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_TYPE(IN_TYPE), .IN_STATE(IN_STATE), .IN_CHARA(IN_CHARA), .IN_NEXT(IN_NEXT),
    .IN_LAST(IN_LAST), .GOTO_COUNT(GOTO_COUNT), .TABLE_VALID(TABLE_VALID), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .RD_ADDR(RD_ADDR), .RD_CUR(RD_CUR), .RD_CHARA(RD_CHARA),
    .RD_NEXT(RD_NEXT), .FAIL_ADDR(FAIL_ADDR), .FAIL_STATE(FAIL_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_ready = 0; m_valid = 0; m_err = 0; m_code = 0; m_cnt = 0; m_known = 0;
  endtask

  task automatic set_err(input logic [1:0] c);
    if (!m_err) m_code = c;
    m_err = 1;
  endtask

  task automatic model_xfer(input bit t, input logic [7:0] s, c, n, input bit last);
    if (!t) begin
      if (m_cnt < 32) begin m_goto[m_cnt] = {s, c, n}; m_cnt++; end
      else set_err(2'd1);
    end else if (s == 0 || s > 32) set_err(2'd2);
    else m_fail[s-1] = n;
    if (last) begin m_ready = 0; m_valid = 1; end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".in_ready"}, IN_READY, m_ready);
    chk({tag, ".table_valid"}, TABLE_VALID, m_valid);
    chk({tag, ".err"}, ERR, m_err);
    chk({tag, ".err_code"}, ERR_CODE, m_code);
    chk({tag, ".goto_count"}, GOTO_COUNT, m_cnt);
  endtask

  task automatic check_tables(input string tag);
    for (int a = 0; a < 32; a++) begin
      RD_ADDR = 5'(a);
      #1 chk($sformatf("%s.goto[%0d]", tag, a), {RD_CUR, RD_CHARA, RD_NEXT}, m_goto[a]);
    end
    for (int s = 0; s < 35; s++) begin
      FAIL_ADDR = 8'(s);
      #1 chk($sformatf("%s.fail[%0d]", tag, s), FAIL_STATE, (s == 0 || s > 32) ? 8'd0 : m_fail[s-1]);
    end
  endtask

  // START pulse (with whatever record the caller left on the bus) then the full sweep
  task automatic do_start(input string tag);
    START = 1;
    tick();
    START = 0;
    IN_VALID = 0;
    IN_LAST = 0;
    model_reset();
    chk({tag, ".sweep_tv"}, TABLE_VALID, 0);
    chk({tag, ".sweep_cnt"}, GOTO_COUNT, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s.sweep_rdy[%0d]", tag, i), IN_READY, 0);
      tick();
    end
    for (int a = 0; a < 32; a++) begin m_goto[a] = 24'hFF0000; m_fail[a] = 0; end
    m_ready = 1;
    m_known = 1;
    chk({tag, ".ready_after_sweep"}, IN_READY, 1);
  endtask

  task automatic send(input bit t, input logic [7:0] s, c, n, input bit last);
    bit acc;
    IN_VALID = 1; IN_TYPE = t; IN_STATE = s; IN_CHARA = c; IN_NEXT = n; IN_LAST = last;
    acc = m_ready;
    tick();
    if (acc) model_xfer(t, s, c, n, last);
  endtask

  task automatic send_random(input bit last);
    bit t;
    t = 1'($urandom_range(0, 1));
    send(t, t ? 8'($urandom_range(0, 34)) : 8'($urandom), 8'($urandom), 8'($urandom), last);
  endtask

  task automatic idle(input int n);
    IN_VALID = 0;
    IN_LAST = 0;
    repeat (n) tick();
  endtask

  initial begin
    #3 RST = 0;
    #1 check_status("reset");
    #8 RST = 1;
    tick();
    check_status("idle");

    do_start("s1");
    check_status("s1");
    check_tables("s1");

    send(0, 8'd0, 8'h61, 8'd1, 0);
    send(0, 8'd1, 8'h62, 8'd2, 0);
    send(1, 8'd2, 8'h00, 8'd0, 0);
    send(1, 8'd1, 8'h00, 8'd0, 1);
    idle(1);
    RD_ADDR = 5'd1;
    #1 chk("basic.rd1", {RD_CUR, RD_CHARA, RD_NEXT}, 24'h016202);
    check_status("basic");
    check_tables("basic");

    do_start("ovf");
    for (int i = 0; i < 33; i++) send(0, 8'($urandom), 8'($urandom), 8'(i + 1), 0);
    idle(1);
    check_status("ovf");
    check_tables("ovf");

    do_start("fidx");
    send(1, 8'd0, 8'h00, 8'h55, 0);
    idle(1);
    check_status("fidx0");
    send(1, 8'd33, 8'h00, 8'h66, 0);
    idle(1);
    check_status("fidx33");
    check_tables("fidx");
    send(1, 8'd32, 8'h00, 8'h77, 0);
    send(1, 8'd32, 8'h00, 8'h78, 1);
    idle(1);
    check_status("fidx_last");
    check_tables("fidx_last");

    do_start("mid");
    for (int i = 0; i < 5; i++) send(0, 8'(i), 8'h41, 8'(i + 1), 0);
    check_status("mid_pre");
    IN_VALID = 1; IN_TYPE = 0; IN_STATE = 8'h09; IN_CHARA = 8'h5A; IN_NEXT = 8'h0A;
    do_start("mid_restart");
    RD_ADDR = 0;
    #1 chk("mid.entry0_cur", RD_CUR, 8'hFF);
    check_status("mid");
    check_tables("mid");

    for (int i = 0; i < 40; i++)
      if ($urandom_range(0, 1) == 1) send_random(0);
      else idle(1);
    IN_VALID = 0;
    check_status("rand_pre_rst");
    #2 RST = 0;
    model_reset();
    #1 check_status("async_rst");
    repeat (3) @(posedge CLK);
    #2 RST = 1;
    IN_VALID = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_status($sformatf("post_rst[%0d]", i));
    end
    IN_VALID = 0;

    do_start("rand2");
    for (int i = 0; i < 60; i++)
      if ($urandom_range(0, 3) != 0) send_random(0);
      else idle(1);
    send_random(1);
    idle(2);
    check_status("rand2");
    check_tables("rand2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/table_writer.md
# table_writer

Loader for the Aho-Corasick goto/failure tables. It owns the goto table (current state, chara, next state) and the failure table, and fills them from a host record stream over a valid/ready handshake. It exposes combinational read ports that the matcher/table-reader path uses once `TABLE_VALID` is high. It sits between the pattern-compiler host interface and the matching datapath.

## Interface
Parameters:
- `DEPTH`, 32: number of goto entries, and number of failure entries (states 1..DEPTH).
- `STATE_W`, 8: state width.
- `CHARA_W`, 8: character width.

Ports:
- `CLK`  in  1  sole clock; everything is on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `START`  in  1  one-cycle pulse that begins a new load session.
- `IN_VALID`  in  1  record present.
- `IN_READY`  out  1  writer accepts a record; a transfer is `IN_VALID & IN_READY`.
- `IN_TYPE`  in  1  0 = goto record, 1 = failure record.
- `IN_STATE`  in  STATE_W  goto: current state; failure: state index.
- `IN_CHARA`  in  CHARA_W  goto character; ignored for failure records.
- `IN_NEXT`  in  STATE_W  goto: next state; failure: failure target.
- `IN_LAST`  in  1  final record of the session.
- `GOTO_COUNT`  out  clog2(DEPTH+1)  number of goto entries written.
- `TABLE_VALID`  out  1  tables complete and readable.
- `ERR`  out  1  sticky error flag.
- `ERR_CODE`  out  2  first error: 0 none, 1 goto overflow, 2 bad failure index.
- `RD_ADDR`  in  clog2(DEPTH)  goto read address.
- `RD_CUR`, `RD_CHARA`, `RD_NEXT`  out  STATE_W/CHARA_W/STATE_W  goto entry at `RD_ADDR` (combinational).
- `FAIL_ADDR`  in  STATE_W  state number (1..DEPTH).
- `FAIL_STATE`  out  STATE_W  failure target of state `FAIL_ADDR`. Returns 0 when `FAIL_ADDR` is 0 or greater than DEPTH.

## Operation
- FSM states:
  - IDLE (reset state).
  - CLEAR: sweeps address `a` = 0..DEPTH-1, one per cycle. Writes goto[a] = {`INVALID_STATE` = 8'hFF, 0, 0} and fail[a] = 0. Clears `GOTO_COUNT` and `ERR`/`ERR_CODE`.
  - LOAD: `IN_READY` = 1.
  - DONE: `IN_READY` = 0 and `TABLE_VALID` = 1.
- `START` in any state moves to CLEAR, restarts the sweep at address 0 and drops `TABLE_VALID` next cycle. A restart mid-CLEAR or mid-LOAD discards the partial session.
- Goto transfer:
  - If `GOTO_COUNT` < DEPTH: write entry at address `GOTO_COUNT`, then increment the count.
  - Otherwise: drop the record and set error 1.
- Failure transfer:
  - If `IN_STATE` is 0 or greater than DEPTH: drop the record and set error 2.
  - Otherwise: fail[`IN_STATE`-1] = `IN_NEXT`. A duplicate index overwrites (last write wins).
- `ERR_CODE` holds the first error. Later errors keep `ERR` = 1 and do not change the code.
- A transfer with `IN_LAST` = 1 is processed normally (including error checks), then the FSM moves to DONE.
- IDLE and DONE ignore `IN_VALID`.
- RAM contents are not reset. `TABLE_VALID` = 0 after reset marks them as don't-care.

## Timing
- Reset values: state IDLE, `IN_READY` 0, `TABLE_VALID` 0, `ERR` 0, `ERR_CODE` 0, `GOTO_COUNT` 0.
- `START` sampled at edge t:
  - CLEAR writes addresses 0..DEPTH-1 at edges t+1..t+DEPTH.
  - `IN_READY` is high from the cycle after edge t+DEPTH.
- Write latency: a record accepted at edge t is visible on the read ports and `GOTO_COUNT` after edge t.
- `IN_LAST` accepted at edge t: `IN_READY` 0 and `TABLE_VALID` 1 after edge t.
- `ERR` rises after the edge of the offending transfer.
- Throughput: one record per cycle in LOAD.
- Read ports have zero latency and are always driven. Only their meaning is gated by `TABLE_VALID`.
- `START` coincident with a transfer: `START` wins and the record is discarded.

## Structure
- Package `ac_table_pkg` holds:
  - `DEPTH`, `STATE_W`, `CHARA_W`, `INVALID_STATE`.
  - Record-type constants (`REC_GOTO`, `REC_FAIL`).
  - Error-code constants (`ERR_NONE`, `ERR_OVF`, `ERR_FIDX`).
  - FSM state enum.
- Sub-module `ac_table_ram`: parameterized simple dual-port RAM, synchronous write and asynchronous read. Instantiated once for goto (packed entry) and once for failure.

## Test plan
- Reset, then `START`; check `IN_READY` 0 for 32 cycles, then 1. Read goto[0..31]: `RD_CUR` = 8'hFF. Read `FAIL_STATE` for 1..32: all 0.
- Load goto {0,'h61,1}, {1,'h62,2}, failure {2→0}, then failure {1→0} with `IN_LAST`. Expect `GOTO_COUNT` = 2, `RD_ADDR` 1 → {1,'h62,2}, `TABLE_VALID` = 1, `IN_READY` = 0, `ERR` = 0.
- Send 33 goto records with `IN_VALID` held high. Expect `GOTO_COUNT` = 32, `ERR` = 1, `ERR_CODE` = 1, and entry 31 equal to record 32.
- Send failure record `IN_STATE` = 0, then `IN_STATE` = 33. Expect `ERR_CODE` = 2 after the first; no failure entry changed.
- `START` in mid-LOAD after 5 gotos. Expect `GOTO_COUNT` = 0, `ERR` cleared, a full re-sweep, and entry 0 reading 8'hFF.
- Toggle `IN_VALID` randomly with a 3-cycle `RST` low pulse mid-LOAD. Expect all outputs at reset values asynchronously, and `IN_READY` staying 0 until the next `START`.
